buf_alloc_client: RTL and testbench
===================================

Name: buf_alloc_client

Overview:
- Requester side of the 16-entry buffer-allocation interface (alloc_raw / nack / alloc_addr / free_raw / free_addr_raw).
- Turns upstream get/put commands into allocator requests and retries nacked allocations with bounded backoff.
- Keeps an in-order FIFO of granted handles and frees the oldest held handle on each put.
- This block is the sole client of one allocator instance.

Parameters:
- ADDR_W, 4, handle width; allocator pool size is 2**ADDR_W.
- DEPTH, 16, handle FIFO capacity; must equal 2**ADDR_W.
- MAX_RETRY, 3, nacked re-attempts before reporting failure; range 0..7.
- BACKOFF, 4, idle cycles between a nack and the next attempt; range 1..15.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- get_req  in  1  request one buffer; sampled only in IDLE.
- get_busy  out  1  high whenever the alloc FSM is not in IDLE.
- get_ack  out  1  one-cycle pulse: buffer granted.
- get_fail  out  1  one-cycle pulse: retries exhausted.
- get_handle  out  ADDR_W  granted handle; valid while get_ack is high.
- put_req  in  1  release the oldest held handle; sampled every cycle.
- put_err  out  1  one-cycle pulse: put_req arrived with FIFO empty.
- held_count  out  ADDR_W+1  number of handles currently held.
- alloc_raw  out  1  allocator request (registered).
- nack  in  1  allocator refusal; valid in the cycle after alloc_raw.
- alloc_addr  in  ADDR_W  allocator's granted address; valid with nack.
- free_raw  out  1  allocator free strobe (registered).
- free_addr_raw  out  ADDR_W  address being freed (registered).

Behaviour:
- Reset values (next cycle after reset high):
  - all outputs 0; FSM in IDLE; FIFO empty; held_count=0; retry counter 0.
  - Reset does not free buffers. The system resets the allocator together with this block.
  - Reset mid-transaction abandons the transaction with no ack/fail pulse.
- Allocator timing contract:
  - The allocator registers alloc_raw at the edge that ends cycle t.
  - nack and alloc_addr are valid during cycle t+1 and commit at the edge ending t+1.
- Alloc FSM, states IDLE, REQ, RESP, BACKOFF:
  - IDLE: get_req=1 -> REQ; retry counter cleared.
  - REQ: alloc_raw=1 for exactly this cycle -> RESP.
  - RESP: alloc_raw=0; sample nack and alloc_addr at the closing edge.
    - nack=0: push alloc_addr into the FIFO. Next cycle: get_ack=1, get_handle=alloc_addr. -> IDLE.
    - nack=1 and retry counter < MAX_RETRY: increment retry counter -> BACKOFF.
    - nack=1 and retry counter = MAX_RETRY: get_fail=1 next cycle -> IDLE.
  - BACKOFF: stay exactly BACKOFF cycles -> REQ.
  - get_req outside IDLE is ignored and not queued.
  - get_busy = (state != IDLE). It is 0 in the cycle get_ack or get_fail is high.
  - Total attempts per get is MAX_RETRY+1.
- Free path (independent of the FSM):
  - put_req=1 with held_count>0: pop the FIFO head. Next cycle: free_raw=1, free_addr_raw=popped handle, for one cycle.
  - put_req=1 with held_count=0: put_err=1 next cycle; no free issued.
  - Emptiness is judged on the pre-edge state. A put in the same cycle as a RESP push with the FIFO empty gives put_err.
  - Free and alloc may be in flight in the same cycle. No ordering is imposed; the allocator handles simultaneous events.
- FIFO:
  - Circular, DEPTH entries, pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: both applied, held_count unchanged.
  - A push while full is impossible when this block is the sole client. It is a checked property and must not corrupt state.
- held_count = pushes − pops, width ADDR_W+1, range 0..DEPTH.
- Embedded properties:
  - held_count <= DEPTH.
  - alloc_raw and free_raw never last two consecutive cycles.
  - free_addr_raw is always a handle that was held, with no duplicates in the FIFO.

Test Plan:
- Reset, then get_req pulse with empty allocator -> alloc_raw high 1 cycle; get_ack 3 cycles after get_req, get_handle=0; held_count=1.
- 16 gets then a 17th -> handles 0..15 in order. The 17th sees nack 4 times with 4-cycle gaps, then get_fail pulse; held_count=16; no 17th push.
- After the 16 grants: put_req -> free_raw with free_addr_raw=0. A following get returns handle 0. FIFO order is now 1..15,0.
- put_req with held_count=0 -> put_err pulse; free_raw stays 0; held_count stays 0.
- put_req in the same cycle as a RESP success with held_count=5 -> free of the oldest handle plus push of the new handle; held_count remains 5.
- Assert reset during BACKOFF after a nack -> no get_fail/get_ack; all outputs 0; FSM in IDLE; held_count=0 next cycle.

Source files
------------

// File: rtl/buf_alloc_client_if.sv
// Signal bundle linking the buffer-allocation client to its upstream command source
// and to the 16-entry allocator it drives.
interface buf_alloc_client_if #(
    parameter int ADDR_W = 4
);
    logic              get_req;
    logic              get_busy;
    logic              get_ack;
    logic              get_fail;
    logic [ADDR_W-1:0] get_handle;
    logic              put_req;
    logic              put_err;
    logic [ADDR_W:0]   held_count;
    logic              alloc_raw;
    logic              nack;
    logic [ADDR_W-1:0] alloc_addr;
    logic              free_raw;
    logic [ADDR_W-1:0] free_addr_raw;

    // slave is the client block; master is the environment (commander plus allocator)
    modport slave (
        input  get_req, put_req, nack, alloc_addr,
        output get_busy, get_ack, get_fail, get_handle, put_err, held_count,
               alloc_raw, free_raw, free_addr_raw
    );

    modport master (
        output get_req, put_req, nack, alloc_addr,
        input  get_busy, get_ack, get_fail, get_handle, put_err, held_count,
               alloc_raw, free_raw, free_addr_raw
    );
endinterface

// File: rtl/buf_alloc_client.sv
// Requester side of a buffer allocator: retries nacked allocations with bounded backoff,
// keeps granted handles in an in-order FIFO and frees the oldest one on each put.
module buf_alloc_client #(
    parameter int ADDR_W    = 4,
    parameter int DEPTH     = 16,
    parameter int MAX_RETRY = 3,
    parameter int BACKOFF   = 4
) (
    input  logic              clock,
    input  logic              reset,
    buf_alloc_client_if.slave bus
);
    localparam logic [2:0]      MAX_RETRY_C = 3'(MAX_RETRY);
    localparam logic [3:0]      BO_LOAD     = 4'(BACKOFF - 1);
    localparam logic [ADDR_W:0] DEPTH_C     = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_BACKOFF} state_t;

    state_t            r_state, w_state_next;
    logic [2:0]        r_retry, w_retry_next;
    logic [3:0]        r_bo_cnt, w_bo_cnt_next;
    logic              w_grant, w_fail;
    logic              r_alloc_raw, r_get_ack, r_get_fail;
    logic [ADDR_W-1:0] r_get_handle;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_full, w_empty, w_push, w_pop;
    logic              r_free_raw, r_put_err;
    logic [ADDR_W-1:0] r_free_addr;
    logic [DEPTH-1:0]  w_dup;

    always_comb begin
        w_state_next  = r_state;
        w_retry_next  = r_retry;
        w_bo_cnt_next = r_bo_cnt;
        w_grant       = 1'b0;
        w_fail        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.get_req) begin
                    w_state_next = S_REQ;
                    w_retry_next = '0;
                end
            end
            S_REQ: w_state_next = S_RESP;
            S_RESP: begin
                if (!bus.nack) begin
                    w_grant      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_retry < MAX_RETRY_C) begin
                    w_retry_next  = r_retry + 3'd1;
                    w_bo_cnt_next = BO_LOAD;
                    w_state_next  = S_BACKOFF;
                end else begin
                    w_fail       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_BACKOFF: begin
                if (r_bo_cnt == 4'd0) w_state_next = S_REQ;
                else                  w_bo_cnt_next = r_bo_cnt - 4'd1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // alloc_raw is a flop loaded from the next state, so it is high exactly in REQ
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_retry      <= '0;
            r_bo_cnt     <= '0;
            r_alloc_raw  <= 1'b0;
            r_get_ack    <= 1'b0;
            r_get_fail   <= 1'b0;
            r_get_handle <= '0;
        end else begin
            r_state     <= w_state_next;
            r_retry     <= w_retry_next;
            r_bo_cnt    <= w_bo_cnt_next;
            r_alloc_raw <= (w_state_next == S_REQ);
            r_get_ack   <= w_grant;
            r_get_fail  <= w_fail;
            if (w_grant) r_get_handle <= bus.alloc_addr;
        end
    end

    // Emptiness uses the pre-edge count, so a put racing the first push reports an error
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_push  = w_grant && !w_full;
    assign w_pop   = bus.put_req && !w_empty;

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.alloc_addr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_free_raw  <= 1'b0;
            r_put_err   <= 1'b0;
            r_free_addr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_free_raw <= w_pop;
            r_put_err  <= bus.put_req && w_empty;
            if (w_pop) r_free_addr <= r_mem[r_rd_ptr];
        end
    end

    // Per-entry match of an incoming grant against handles already held
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dup
            logic [ADDR_W-1:0] w_ofs;
            assign w_ofs     = ADDR_W'(gi) - r_rd_ptr;
            assign w_dup[gi] = ({1'b0, w_ofs} < r_count) && (r_mem[gi] == bus.alloc_addr);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (r_count <= DEPTH_C);
            assert (!(w_grant && w_full));
            assert (!(w_grant && (|w_dup)));
            assert (!(r_alloc_raw && (w_state_next == S_REQ)));
        end
    end

    assign bus.get_busy      = (r_state != S_IDLE);
    assign bus.get_ack       = r_get_ack;
    assign bus.get_fail      = r_get_fail;
    assign bus.get_handle    = r_get_handle;
    assign bus.put_err       = r_put_err;
    assign bus.held_count    = r_count;
    assign bus.alloc_raw     = r_alloc_raw;
    assign bus.free_raw      = r_free_raw;
    assign bus.free_addr_raw = r_free_addr;
endmodule

// File: tb/tb_buf_alloc_client.sv
// Bench for buf_alloc_client: behavioural allocator plus a cycle-indexed expectation model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_buf_alloc_client;
    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 16;
    localparam int MAX_RETRY = 3;
    localparam int BACKOFF   = 4;
    localparam int NCYC      = 8192;
    localparam int NEVER     = 32'h7fff_ffff;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    buf_alloc_client_if #(.ADDR_W(ADDR_W)) bus ();

    buf_alloc_client #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .BACKOFF(BACKOFF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Allocator: grants the lowest free address, refuses when full or when told to
    logic [DEPTH-1:0] used;
    logic             pend;
    logic             inject;
    int               lowest;

    always_comb begin
        lowest = DEPTH;
        for (int i = DEPTH - 1; i >= 0; i--) if (!used[i]) lowest = i;
    end
    assign bus.nack       = pend && (inject || (lowest == DEPTH));
    assign bus.alloc_addr = ADDR_W'(lowest);

    always @(posedge clock) begin
        if (reset) begin
            used <= '0;
            pend <= 1'b0;
        end else begin
            pend <= bus.alloc_raw;
            if (pend && !bus.nack) used[bus.alloc_addr] <= 1'b1;
            if (bus.free_raw)      used[bus.free_addr_raw] <= 1'b0;
        end
    end

    // Reference model: expectations scheduled by cycle number from the get/put rules
    bit                exp_alloc [NCYC];
    bit                exp_ack   [NCYC];
    bit                exp_fail  [NCYC];
    bit                exp_free  [NCYC];
    bit                exp_perr  [NCYC];
    logic [ADDR_W-1:0] exp_handle[NCYC];
    logic [ADDR_W-1:0] exp_faddr [NCYC];
    logic [ADDR_W-1:0] held[$];
    int                free_at = 0;
    int                att     = 0;
    int                tries   = 0;
    bit                in_txn  = 1'b0;
    bit                chk_en  = 1'b0;

    always @(negedge clock) begin
        if (chk_en && cyc < NCYC) begin
            check("alloc_raw",  32'(bus.alloc_raw),  32'(exp_alloc[cyc]));
            check("get_ack",    32'(bus.get_ack),    32'(exp_ack[cyc]));
            check("get_fail",   32'(bus.get_fail),   32'(exp_fail[cyc]));
            check("free_raw",   32'(bus.free_raw),   32'(exp_free[cyc]));
            check("put_err",    32'(bus.put_err),    32'(exp_perr[cyc]));
            check("get_busy",   32'(bus.get_busy),   32'(cyc < free_at));
            check("held_count", 32'(bus.held_count), 32'(held.size()));
            if (exp_ack[cyc])  check("get_handle",    32'(bus.get_handle),    32'(exp_handle[cyc]));
            if (exp_free[cyc]) check("free_addr_raw", 32'(bus.free_addr_raw), 32'(exp_faddr[cyc]));
        end
        if (cyc < NCYC - 64) begin
            if (reset) begin
                held.delete();
                in_txn  = 1'b0;
                free_at = cyc + 1;
                chk_en  = 1'b1;
                for (int k = cyc + 1; k < cyc + 64; k++) begin
                    exp_alloc[k] = 1'b0;
                    exp_ack[k]   = 1'b0;
                    exp_fail[k]  = 1'b0;
                    exp_free[k]  = 1'b0;
                    exp_perr[k]  = 1'b0;
                end
            end else if (chk_en) begin
                if (bus.put_req) begin
                    if (held.size() == 0) exp_perr[cyc+1] = 1'b1;
                    else begin
                        exp_free[cyc+1]  = 1'b1;
                        exp_faddr[cyc+1] = held.pop_front();
                    end
                end
                if (in_txn && cyc == att + 1) begin
                    if (!bus.nack) begin
                        held.push_back(bus.alloc_addr);
                        exp_ack[cyc+1]    = 1'b1;
                        exp_handle[cyc+1] = bus.alloc_addr;
                        in_txn            = 1'b0;
                        free_at           = cyc + 1;
                    end else if (tries < MAX_RETRY) begin
                        tries++;
                        att            = att + BACKOFF + 2;
                        exp_alloc[att] = 1'b1;
                    end else begin
                        exp_fail[cyc+1] = 1'b1;
                        in_txn          = 1'b0;
                        free_at         = cyc + 1;
                    end
                end else if (!in_txn && bus.get_req) begin
                    in_txn         = 1'b1;
                    tries          = 0;
                    att            = cyc + 1;
                    exp_alloc[att] = 1'b1;
                    free_at        = NEVER;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_get(output int res, output logic [ADDR_W-1:0] h,
                          output int lat, output int n_alloc);
        bit done;
        bus.get_req = 1'b1;
        tick();
        bus.get_req = 1'b0;
        res = 0; h = '0; lat = 1; n_alloc = 0; done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (bus.alloc_raw) n_alloc++;
            if (bus.get_ack) begin
                res = 1; h = bus.get_handle; done = 1'b1;
            end else if (bus.get_fail) begin
                res = 2; done = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
        check("get_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int                res, lat, n_alloc;
        logic [ADDR_W-1:0] h;

        bus.get_req = 1'b0;
        bus.put_req = 1'b0;
        inject      = 1'b0;
        reset       = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_alloc_raw",  32'(bus.alloc_raw),  32'd0);
        check("rst_get_busy",   32'(bus.get_busy),   32'd0);
        check("rst_get_ack",    32'(bus.get_ack),    32'd0);
        check("rst_get_fail",   32'(bus.get_fail),   32'd0);
        check("rst_free_raw",   32'(bus.free_raw),   32'd0);
        check("rst_put_err",    32'(bus.put_err),    32'd0);
        check("rst_held_count", 32'(bus.held_count), 32'd0);
        check("rst_get_handle", 32'(bus.get_handle), 32'd0);
        check("rst_free_addr",  32'(bus.free_addr_raw), 32'd0);

        // First get: alloc_raw one cycle later, ack three cycles after the request
        bus.get_req = 1'b1;
        tick();
        bus.get_req = 1'b0;
        check("t1_alloc_hi", 32'(bus.alloc_raw), 32'd1);
        check("t1_busy_hi",  32'(bus.get_busy),  32'd1);
        tick();
        check("t1_alloc_lo", 32'(bus.alloc_raw), 32'd0);
        tick();
        check("t1_ack",      32'(bus.get_ack),    32'd1);
        check("t1_handle",   32'(bus.get_handle), 32'd0);
        check("t1_held",     32'(bus.held_count), 32'd1);
        check("t1_busy_lo",  32'(bus.get_busy),   32'd0);

        for (int k = 1; k < DEPTH; k++) begin
            do_get(res, h, lat, n_alloc);
            check("fill_res",    32'(res), 32'd1);
            check("fill_handle", 32'(h),   32'(k));
        end
        do_get(res, h, lat, n_alloc);
        check("full_res",     32'(res),            32'd2);
        check("full_latency", 32'(lat),            32'd21);
        check("full_attempts",32'(n_alloc),        32'd4);
        check("full_held",    32'(bus.held_count), 32'd16);

        bus.put_req = 1'b1;
        tick();
        bus.put_req = 1'b0;
        check("put1_free",  32'(bus.free_raw),      32'd1);
        check("put1_addr",  32'(bus.free_addr_raw), 32'd0);
        check("put1_held",  32'(bus.held_count),    32'd15);
        do_get(res, h, lat, n_alloc);
        check("reget_handle", 32'(h),               32'd0);
        check("reget_held",   32'(bus.held_count),  32'd16);

        // Drain: order must now be 1..15 then 0
        bus.put_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (i == DEPTH - 1) bus.put_req = 1'b0;
            check("drain_free", 32'(bus.free_raw),      32'd1);
            check("drain_addr", 32'(bus.free_addr_raw), (i < DEPTH - 1) ? 32'(i + 1) : 32'd0);
        end
        bus.put_req = 1'b1;
        tick();
        bus.put_req = 1'b0;
        check("empty_put_err",  32'(bus.put_err),    32'd1);
        check("empty_free_raw", 32'(bus.free_raw),   32'd0);
        check("empty_held",     32'(bus.held_count), 32'd0);
        tick();
        check("empty_put_err_lo", 32'(bus.put_err),  32'd0);

        for (int k = 0; k < 5; k++) begin
            do_get(res, h, lat, n_alloc);
            check("five_handle", 32'(h), 32'(k));
        end
        // Put lands in the RESP cycle of a successful get
        bus.get_req = 1'b1;
        tick();
        bus.get_req = 1'b0;
        tick();
        bus.put_req = 1'b1;
        tick();
        bus.put_req = 1'b0;
        check("sim_ack",    32'(bus.get_ack),       32'd1);
        check("sim_handle", 32'(bus.get_handle),    32'd5);
        check("sim_free",   32'(bus.free_raw),      32'd1);
        check("sim_faddr",  32'(bus.free_addr_raw), 32'd0);
        check("sim_held",   32'(bus.held_count),    32'd5);

        // Reset while backing off after a nack
        inject      = 1'b1;
        bus.get_req = 1'b1;
        tick();
        bus.get_req = 1'b0;
        repeat (3) tick();
        check("bo_busy", 32'(bus.get_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        inject = 1'b0;
        check("bo_rst_busy",  32'(bus.get_busy),   32'd0);
        check("bo_rst_held",  32'(bus.held_count), 32'd0);
        check("bo_rst_alloc", 32'(bus.alloc_raw),  32'd0);
        for (int i = 0; i < 25; i++) begin
            tick();
            check("bo_no_pulse", 32'({bus.get_ack, bus.get_fail}), 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            bus.get_req = ($urandom_range(0, 3) == 0);
            bus.put_req = (i < 1000) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 3) == 0);
            inject      = ($urandom_range(0, 9) < 3);
            reset       = ($urandom_range(0, 399) == 0);
            tick();
        end
        bus.get_req = 1'b0;
        bus.put_req = 1'b0;
        inject      = 1'b0;
        reset       = 1'b0;
        repeat (30) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
